mem_access_unit: RTL and testbench

Load/store sequencer sitting directly downstream of the SCPU control decoder and ALU. It takes the decoded memory command (MemRW, Length) plus the ALU-computed address and rs2 data, and runs a request/ready handshake with the MIO bus. It generates byte-lane masks and replicated store data, sign/zero-extends load data, and stalls the core until the access completes, faults on misalignment, or times out.

---
 rtl/mem_pkg.sv | 60 ++++++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, Length field decoding and defaults for the load/store sequencer.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam int LEN_WORD_BIT   = 2;
    localparam int LEN_HALF_BIT   = 1;
    localparam int LEN_SIGNED_BIT = 0;

    localparam logic [2:0] LEN_BU = 3'b000;
    localparam logic [2:0] LEN_B  = 3'b001;
    localparam logic [2:0] LEN_HU = 3'b010;
    localparam logic [2:0] LEN_H  = 3'b011;
    localparam logic [2:0] LEN_W  = 3'b100;

    localparam int DEFAULT_TIMEOUT = 16;

    function automatic size_t len_to_size(input logic [2:0] len);
        size_t s;
        if (len[LEN_WORD_BIT])
            s = SZ_WORD;
        else if (len[LEN_HALF_BIT])
            s = SZ_HALF;
        else
            s = SZ_BYTE;
        return s;
    endfunction

    // Stores have no signed variants, so only the unsigned encodings are legal for them.
    function automatic logic len_is_legal(input logic is_store, input logic [2:0] len);
        logic ok;
        case (len)
            LEN_BU, LEN_HU, LEN_W: ok = 1'b1;
            LEN_B, LEN_H:          ok = !is_store;
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_HALF: mis = off[0];
            SZ_WORD: mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store mask/data replication and load lane extraction with extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_t       size,
    input  logic        sgn,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[{offset, 3'b000} +: 8];
        half_lane = rdata[{offset[1], 4'b0000} +: 16];
        wmask     = 4'b1111;
        wdata_rep = wdata;
        load_ext  = rdata;
        case (size)
            SZ_BYTE: begin
                wmask     = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                load_ext  = {{24{sgn & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                wmask     = 4'b0011 << {offset[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                load_ext  = {{16{sgn & half_lane[15]}}, half_lane};
            end
            default: begin
                wmask     = 4'b1111;
                wdata_rep = wdata;
                load_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: IDLE/BUSY/DONE handshake with the MIO bus, alignment faults and timeout.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_en,
    input  logic        MemRW,
    input  logic [2:0]  Length,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    input  logic        MIO_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    output logic [31:0] load_data,
    output logic        done,
    output logic        err,
    output logic        stall
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_wmask_q, bus_wmask_d;
    logic [31:0] load_data_q, load_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        sgn_q, sgn_d;
    size_t       size_q, size_d;
    logic [1:0]  off_q, off_d;

    size_t       cmd_size;
    logic        cmd_bad;
    size_t       align_size;
    logic [1:0]  align_off;
    logic [3:0]  align_wmask;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    // One aligner serves both phases: live command while IDLE, latched access while BUSY.
    assign align_size = (state_q == ST_BUSY) ? size_q : cmd_size;
    assign align_off  = (state_q == ST_BUSY) ? off_q  : addr[1:0];

    mem_lane_align u_align (
        .size      (align_size),
        .sgn       (sgn_q),
        .offset    (align_off),
        .wdata     (wdata),
        .rdata     (bus_rdata),
        .wmask     (align_wmask),
        .wdata_rep (align_wdata),
        .load_ext  (align_load)
    );

    always_comb begin
        cmd_size = len_to_size(Length);
        cmd_bad  = !len_is_legal(MemRW, Length) || is_misaligned(cmd_size, addr[1:0]);

        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sgn_d       = sgn_q;
        size_d      = size_q;
        off_d       = off_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_en && cmd_bad) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (mem_en) begin
                    state_d     = ST_BUSY;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = MemRW;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_wdata_d = MemRW ? align_wdata : 32'h0;
                    bus_wmask_d = MemRW ? align_wmask : 4'b0000;
                    sgn_d       = Length[LEN_SIGNED_BIT];
                    size_d      = cmd_size;
                    off_d       = addr[1:0];
                end
            end
            ST_BUSY: begin
                // Ready takes priority over a timeout landing on the same cycle.
                if (MIO_ready) begin
                    if (!bus_we_q)
                        load_data_d = align_load;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    err_d     = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wmask_q <= 4'b0000;
            load_data_q <= 32'h0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= SZ_BYTE;
            off_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
            load_data_q <= load_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            off_q       <= off_d;
        end
    end

    assign stall     = ((state_q == ST_IDLE) && mem_en) || (state_q == ST_BUSY);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;
    assign load_data = load_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes model predictions, monitor pops on done/bus_req.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mem_en = 1'b0;
    logic        MemRW = 1'b0;
    logic [2:0]  Length = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] bus_rdata = 32'h0;
    logic        MIO_ready = 1'b0;
    logic        bus_req, bus_we, done, err, stall;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_wmask;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_en    (mem_en),
        .MemRW     (MemRW),
        .Length    (Length),
        .addr      (addr),
        .wdata     (wdata),
        .bus_rdata (bus_rdata),
        .MIO_ready (MIO_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wmask (bus_wmask),
        .load_data (load_data),
        .done      (done),
        .err       (err),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model_load = 32'h0;

    typedef struct {
        bit          err;
        bit          no_bus;
        bit          aborted;
        bit          is_store;
        logic [31:0] load_data;
        logic [31:0] addr_w;
        logic [3:0]  mask;
        logic [31:0] wdata;
        int          done_cycle;
        int          busy_cycles;
    } exp_t;

    exp_t sb_q[$];

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic flagFail(input string nm);
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL %s: event not as required at cycle %0d", nm, cyc);
    endtask

    // Reference: k = number of BUSY cycles before ready; k >= TO means the bus never answers.
    task automatic modelTxn(input bit st, input logic [2:0] len, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int k,
                            input int start, output exp_t e);
        int          nb;
        bit          legal;
        logic [31:0] v;
        logic [31:0] m;
        legal = st ? (len == 3'd0 || len == 3'd2 || len == 3'd4) : (len <= 3'd4);
        nb = len[2] ? 4 : (len[1] ? 2 : 1);
        e.is_store = st;
        e.aborted  = 1'b0;
        e.addr_w   = a & 32'hFFFF_FFFC;
        e.mask     = 4'b0000;
        e.wdata    = 32'h0;
        if (!legal || (a % nb) != 0) begin
            e.err         = 1'b1;
            e.no_bus      = 1'b1;
            e.done_cycle  = start + 1;
            e.busy_cycles = 0;
        end else begin
            e.no_bus = 1'b0;
            if (st) begin
                e.mask  = 4'(((1 << nb) - 1) << (a % 4));
                e.wdata = (nb == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                          (nb == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
            end
            if (k < TO) begin
                e.err         = 1'b0;
                e.done_cycle  = start + 2 + k;
                e.busy_cycles = k + 1;
                if (!st) begin
                    m = (nb == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nb)) - 1);
                    v = (rd >> (8 * (a % 4))) & m;
                    if (len[0] && nb < 4 && v[8 * nb - 1])
                        v = v | ~m;
                    model_load = v;
                end
            end else begin
                e.err         = 1'b1;
                e.done_cycle  = start + 1 + TO;
                e.busy_cycles = TO;
            end
        end
        e.load_data = model_load;
    endtask

    task automatic applyStimulus(input bit st, input logic [2:0] len, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int k);
        exp_t e;
        int   busy;
        bit   seen;
        @(negedge clk);
        modelTxn(st, len, a, wd, rd, k, cyc, e);
        sb_q.push_back(e);
        mem_en    = 1'b1;
        MemRW     = st;
        Length    = len;
        addr      = a;
        wdata     = wd;
        MIO_ready = 1'($urandom % 2);
        bus_rdata = $urandom;
        #1 checkOutput("stall_on_issue", 32'(stall), 32'h1);
        busy = 0;
        seen = 1'b0;
        for (int t = 0; t < TO + 8 && !seen; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                MIO_ready = 1'($urandom % 2);
                #1 checkOutput("stall_at_done", 32'(stall), 32'h0);
            end else if (bus_req) begin
                MIO_ready = (busy == k);
                bus_rdata = (busy == k) ? rd : $urandom;
                busy++;
            end else begin
                MIO_ready = 1'($urandom % 2);
                bus_rdata = $urandom;
            end
        end
        if (!seen) begin
            flagFail("done_timeout");
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            checkOutput("busy_cycles", 32'(busy), 32'(e.busy_cycles));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_bus_req"}, 32'(bus_req), 32'h0);
        checkOutput({tag, "_bus_we"}, 32'(bus_we), 32'h0);
        checkOutput({tag, "_bus_addr"}, bus_addr, 32'h0);
        checkOutput({tag, "_bus_wdata"}, bus_wdata, 32'h0);
        checkOutput({tag, "_bus_wmask"}, 32'(bus_wmask), 32'h0);
        checkOutput({tag, "_load_data"}, load_data, 32'h0);
        checkOutput({tag, "_done"}, 32'(done), 32'h0);
        checkOutput({tag, "_err"}, 32'(err), 32'h0);
        checkOutput({tag, "_stall"}, 32'(stall), 32'h0);
    endtask

    task automatic resetDuringBusy(input logic [31:0] a);
        exp_t e;
        bit   seen;
        @(negedge clk);
        modelTxn(1'b0, 3'b100, a, 32'h0, 32'h0, TO + 2, cyc, e);
        e.aborted = 1'b1;
        sb_q.push_back(e);
        mem_en    = 1'b1;
        MemRW     = 1'b0;
        Length    = 3'b100;
        addr      = a;
        MIO_ready = 1'b0;
        seen      = 1'b0;
        for (int t = 0; t < 4 && !seen; t++) begin
            @(negedge clk);
            if (bus_req) seen = 1'b1;
        end
        if (!seen) flagFail("rst_busy_no_req");
        rstn      = 1'b0;
        mem_en    = 1'b0;
        MIO_ready = 1'b1;
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        model_load = 32'h0;
        @(negedge clk);
        checkResetState("rst_mid_busy");
        rstn      = 1'b1;
        MIO_ready = 1'b0;
    endtask

    // Monitor: bus fields checked against the in-flight prediction, completions popped on done.
    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (bus_req) begin
                if (sb_q.size() == 0) begin
                    flagFail("unexpected_bus_req");
                end else begin
                    m = sb_q[0];
                    if (m.no_bus) begin
                        checkOutput("bus_req_on_fault", 32'(bus_req), 32'h0);
                    end else begin
                        checkOutput("bus_we", 32'(bus_we), 32'(m.is_store));
                        checkOutput("bus_addr", bus_addr, m.addr_w);
                        checkOutput("bus_wmask", 32'(bus_wmask), 32'(m.mask));
                        if (m.is_store)
                            checkOutput("bus_wdata", bus_wdata, m.wdata);
                    end
                end
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    flagFail("unexpected_done");
                end else begin
                    m = sb_q.pop_front();
                    if (m.aborted) flagFail("done_after_reset");
                    checkOutput("err", 32'(err), 32'(m.err));
                    checkOutput("load_data", load_data, m.load_data);
                    checkOutput("done_cycle", 32'(cyc), 32'(m.done_cycle));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("init");
        rstn = 1'b1;

        applyStimulus(1'b0, 3'b100, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        checkOutput("lw_value", load_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'h8012_3456, 1);
        checkOutput("lb_value", load_data, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8012_3456, 0);
        checkOutput("lbu_value", load_data, 32'h0000_0080);
        applyStimulus(1'b1, 3'b010, 32'h0000_0206, 32'h1234_ABCD, $urandom, 0);
        checkOutput("sh_keeps_load", load_data, 32'h0000_0080);
        applyStimulus(1'b0, 3'b100, 32'h0000_0102, 32'h0, $urandom, 0);
        checkOutput("misaligned_keeps_load", load_data, 32'h0000_0080);
        applyStimulus(1'b1, 3'b100, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, TO + 2);
        applyStimulus(1'b1, 3'b100, 32'h0000_0304, 32'h0BAD_CAFE, 32'h0, TO - 1);
        applyStimulus(1'b0, 3'b011, 32'h0000_0012, 32'h0, 32'h9ABC_1234, TO - 1);
        applyStimulus(1'b1, 3'b001, 32'h0000_0400, 32'h1111_2222, 32'h0, 0);
        applyStimulus(1'b0, 3'b111, 32'h0000_0400, 32'h0, 32'h0, 0);
        resetDuringBusy(32'h0000_0500);
        applyStimulus(1'b0, 3'b100, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 2);
        checkOutput("lw_after_reset", load_data, 32'h1357_9BDF);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                mem_en = 1'b0;
            end
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            applyStimulus(1'($urandom % 2), 3'($urandom_range(0, 7)), ra, $urandom, $urandom,
                          $urandom_range(0, TO + 1));
        end

        @(negedge clk);
        mem_en = 1'b0;
        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) flagFail("scoreboard_not_empty");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
